// File: rtl/mtimer_multi.sv
// rtl/mtimer_multi.sv - prescaled 64-bit machine timer with NCH compare channels
// Compare values load atomically via a high-half shadow; periodic channels self-reload.
module mtimer_multi #(
  parameter int NCH     = 4,
  parameter int PRESC_W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           we_i,
  input  logic           re_i,
  input  logic [7:0]     addr_i,
  input  logic [31:0]    wdata_i,
  output logic [31:0]    rdata_o,
  output logic [NCH-1:0] irq_o,
  output logic           irq_any_o
);

  logic [63:0]          mtime;
  logic [PRESC_W-1:0]   pcnt;
  logic [PRESC_W-1:0]   presc;
  logic [31:0]          snap_hi;
  logic                 en;
  logic [NCH-1:0]       pend;
  logic [NCH-1:0]       ie;
  logic [NCH-1:0]       periodic;
  logic [NCH-1:0]       ch_en;
  logic [NCH-1:0]       match;
  logic [NCH-1:0]       ch_sel;
  logic [NCH-1:0][63:0] cmp;
  logic [NCH-1:0][31:0] shadow_hi;
  logic [NCH-1:0][31:0] period;

  logic wr_lo, wr_hi, wr_ctrl, wr_presc, wr_pend, wr_ie, tick;

  assign wr_lo    = we_i && (addr_i == 8'h00);
  assign wr_hi    = we_i && (addr_i == 8'h01);
  assign wr_ctrl  = we_i && (addr_i == 8'h02);
  assign wr_presc = we_i && (addr_i == 8'h03);
  assign wr_pend  = we_i && (addr_i == 8'h04);
  assign wr_ie    = we_i && (addr_i == 8'h05);
  assign tick     = en && (pcnt == presc);

  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      ch_sel[k] = (addr_i[7:2] == 6'(4 + k));
      match[k]  = ch_en[k] && (mtime >= cmp[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime     <= '0;
      pcnt      <= '0;
      presc     <= '0;
      snap_hi   <= '0;
      en        <= 1'b0;
      pend      <= '0;
      ie        <= '0;
      periodic  <= '0;
      ch_en     <= '0;
      period    <= '0;
      cmp       <= '1;
      shadow_hi <= '1;
    end else begin
      if (wr_presc)
        pcnt <= '0;
      else if (en)
        pcnt <= tick ? '0 : pcnt + PRESC_W'(1);

      if (wr_lo)
        mtime[31:0] <= wdata_i;
      else if (wr_hi)
        mtime[63:32] <= wdata_i;
      else if (tick)
        mtime <= mtime + 64'd1;

      if (re_i && (addr_i == 8'h00))
        snap_hi <= mtime[63:32];
      if (wr_ctrl)
        en <= wdata_i[0];
      if (wr_presc)
        presc <= wdata_i[PRESC_W-1:0];
      if (wr_ie)
        ie <= wdata_i[NCH-1:0];

      // match sets win over a same-cycle software clear
      pend <= (pend & ~(wr_pend ? wdata_i[NCH-1:0] : '0)) | match;

      for (int k = 0; k < NCH; k++) begin
        if (match[k] && periodic[k] && (period[k] != 32'd0))
          cmp[k] <= cmp[k] + {32'd0, period[k]};
        // software writes are placed last so they override the reload
        if (we_i && ch_sel[k]) begin
          case (addr_i[1:0])
            2'd0: cmp[k] <= {shadow_hi[k], wdata_i};
            2'd1: shadow_hi[k] <= wdata_i;
            2'd2: period[k] <= wdata_i;
            default: begin
              periodic[k] <= wdata_i[0];
              ch_en[k]    <= wdata_i[1];
            end
          endcase
        end
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    case (addr_i)
      8'h00:   rdata_o = mtime[31:0];
      8'h01:   rdata_o = snap_hi;
      8'h02:   rdata_o = {31'd0, en};
      8'h03:   rdata_o = 32'(presc);
      8'h04:   rdata_o = 32'(pend);
      8'h05:   rdata_o = 32'(ie);
      default: rdata_o = '0;
    endcase
    for (int k = 0; k < NCH; k++) begin
      if (ch_sel[k]) begin
        case (addr_i[1:0])
          2'd0:    rdata_o = cmp[k][31:0];
          2'd1:    rdata_o = cmp[k][63:32];
          2'd2:    rdata_o = period[k];
          default: rdata_o = {30'd0, ch_en[k], periodic[k]};
        endcase
      end
    end
  end

  assign irq_o     = pend & ie;
  assign irq_any_o = |irq_o;

endmodule

// File: tb/tb_mtimer_multi.sv
// tb/tb_mtimer_multi.sv - directed self-checking bench for mtimer_multi
module tb_mtimer_multi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we_i = 1'b0;
  logic        re_i = 1'b0;
  logic [7:0]  addr_i = 8'h00;
  logic [31:0] wdata_i = 32'h0;
  logic [31:0] rdata_o;
  logic [3:0]  irq_o;
  logic        irq_any_o;

  int n_tests = 0;
  int n_fail  = 0;

  mtimer_multi #(.NCH(4), .PRESC_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (we_i),
    .re_i      (re_i),
    .addr_i    (addr_i),
    .wdata_i   (wdata_i),
    .rdata_o   (rdata_o),
    .irq_o     (irq_o),
    .irq_any_o (irq_any_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // called near a negedge; the write lands on the next posedge
  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    we_i = 1'b1; addr_i = a; wdata_i = d;
    @(negedge clk);
    we_i = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
    addr_i = a;
    #1;
    check(tag, {32'd0, rdata_o}, {32'd0, exp});
  endtask

  task automatic snap();
    re_i = 1'b1; addr_i = 8'h00;
    @(negedge clk);
    re_i = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rd("rst_mtime_lo_async", 8'h00, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    rd("rst_mtime_lo", 8'h00, 32'h0);
    rd("rst_snap_hi", 8'h01, 32'h0);
    rd("rst_ctrl", 8'h02, 32'h0);
    rd("rst_cmp0_lo", 8'h10, 32'hFFFF_FFFF);
    rd("rst_cmp0_hi", 8'h11, 32'hFFFF_FFFF);
    rd("rst_cmp3_hi", 8'h1D, 32'hFFFF_FFFF);
    check("rst_irq", {60'd0, irq_o}, 64'd0);
    wr(8'h20, 32'h1234_5678);
    rd("unmapped_ch4", 8'h20, 32'h0);
    rd("unmapped_06", 8'h06, 32'h0);
    rd("unmapped_0f", 8'h0F, 32'h0);

    // prescaler: PRESC=3 gives one tick per 4 cycles
    @(negedge clk);
    wr(8'h03, 32'd3);
    wr(8'h00, 32'd0);
    wr(8'h01, 32'd0);
    wr(8'h02, 32'd1);
    repeat (3) @(negedge clk);
    rd("presc_before_tick", 8'h00, 32'd0);
    @(negedge clk);
    rd("presc_first_tick", 8'h00, 32'd1);
    repeat (36) @(negedge clk);
    rd("presc_40_cycles", 8'h00, 32'd10);
    wr(8'h02, 32'd0);
    repeat (10) @(negedge clk);
    rd("presc_frozen", 8'h00, 32'd10);

    // channel 0 one-shot at 5
    wr(8'h00, 32'd0);
    wr(8'h03, 32'd0);
    wr(8'h11, 32'd0);
    wr(8'h10, 32'd5);
    wr(8'h05, 32'd1);
    wr(8'h13, 32'd2);
    wr(8'h02, 32'd1);
    repeat (5) @(negedge clk);
    rd("os_mtime5", 8'h00, 32'd5);
    check("os_irq_before", {60'd0, irq_o}, 64'd0);
    @(negedge clk);
    check("os_irq_after", {60'd0, irq_o}, 64'd1);
    check("os_irq_any", {63'd0, irq_any_o}, 64'd1);
    wr(8'h04, 32'd1);
    rd("os_clear_loses", 8'h04, 32'd1);
    wr(8'h13, 32'd0);
    wr(8'h04, 32'd1);
    rd("os_cleared", 8'h04, 32'd0);
    wr(8'h13, 32'd2);
    rd("os_not_yet", 8'h04, 32'd0);
    @(negedge clk);
    rd("os_repend", 8'h04, 32'd1);
    wr(8'h13, 32'd0);
    wr(8'h04, 32'd1);
    wr(8'h02, 32'd0);

    // channel 1 periodic, period 10
    wr(8'h00, 32'd0);
    wr(8'h01, 32'd0);
    wr(8'h15, 32'd0);
    wr(8'h14, 32'd10);
    wr(8'h16, 32'd10);
    wr(8'h17, 32'd3);
    wr(8'h05, 32'd2);
    wr(8'h04, 32'hF);
    wr(8'h02, 32'd1);
    repeat (10) @(negedge clk);
    rd("per_no_pend_yet", 8'h04, 32'd0);
    rd("per_cmp10", 8'h14, 32'd10);
    @(negedge clk);
    rd("per_pend1", 8'h04, 32'd2);
    rd("per_cmp20", 8'h14, 32'd20);
    check("per_irq1", {60'd0, irq_o}, 64'd2);
    wr(8'h04, 32'd2);
    rd("per_clr1", 8'h04, 32'd0);
    repeat (8) @(negedge clk);
    rd("per_wait2", 8'h04, 32'd0);
    @(negedge clk);
    rd("per_pend2", 8'h04, 32'd2);
    rd("per_cmp30", 8'h14, 32'd30);
    wr(8'h04, 32'd2);
    rd("per_clr2", 8'h04, 32'd0);
    repeat (8) @(negedge clk);
    rd("per_wait3", 8'h04, 32'd0);
    @(negedge clk);
    rd("per_pend3", 8'h04, 32'd2);
    rd("per_cmp40", 8'h14, 32'd40);
    rd("per_cmp40_hi", 8'h15, 32'd0);
    wr(8'h02, 32'd0);
    wr(8'h17, 32'd0);
    wr(8'h04, 32'hF);

    // high-half snapshot across a low-half rollover
    wr(8'h00, 32'hFFFF_FFFF);
    wr(8'h01, 32'd1);
    snap();
    rd("snap_before", 8'h01, 32'd1);
    wr(8'h02, 32'd1);
    @(negedge clk);
    rd("snap_lo_rolled", 8'h00, 32'd0);
    rd("snap_held", 8'h01, 32'd1);
    wr(8'h02, 32'd0);
    snap();
    rd("snap_new", 8'h01, 32'd2);

    // shadowed compare load on channel 2
    wr(8'h05, 32'd4);
    wr(8'h1B, 32'd2);
    wr(8'h19, 32'd0);
    @(negedge clk);
    check("shadow_no_irq", {60'd0, irq_o}, 64'd0);
    rd("shadow_hi_unchanged", 8'h19, 32'hFFFF_FFFF);
    rd("shadow_lo_unchanged", 8'h18, 32'hFFFF_FFFF);
    wr(8'h18, 32'h100);
    rd("cmp2_lo", 8'h18, 32'h100);
    rd("cmp2_hi", 8'h19, 32'h0);
    @(negedge clk);
    check("cmp2_irq", {60'd0, irq_o}, 64'd4);

    // all four pending, then reset mid-count
    wr(8'h13, 32'd2);
    wr(8'h17, 32'd2);
    wr(8'h1D, 32'd0);
    wr(8'h1C, 32'd0);
    wr(8'h1F, 32'd2);
    wr(8'h05, 32'hF);
    wr(8'h03, 32'd3);
    wr(8'h02, 32'd1);
    repeat (2) @(negedge clk);
    check("all_irq", {60'd0, irq_o}, 64'hF);
    rd("all_pend", 8'h04, 32'hF);
    rst_n = 1'b0;
    #1;
    check("rst_irq_now", {60'd0, irq_o}, 64'd0);
    check("rst_irq_any_now", {63'd0, irq_any_o}, 64'd0);
    rd("rst2_mtime_lo", 8'h00, 32'd0);
    rd("rst2_snap", 8'h01, 32'd0);
    rd("rst2_ctrl", 8'h02, 32'd0);
    rd("rst2_presc", 8'h03, 32'd0);
    rd("rst2_pend", 8'h04, 32'd0);
    rd("rst2_ie", 8'h05, 32'd0);
    rd("rst2_cmp0_lo", 8'h10, 32'hFFFF_FFFF);
    rd("rst2_cmp1_hi", 8'h15, 32'hFFFF_FFFF);
    rd("rst2_period1", 8'h16, 32'd0);
    rd("rst2_chctl3", 8'h1F, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_irq", {60'd0, irq_o}, 64'd0);
    rd("post_rst_mtime", 8'h00, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
